zacore_mem_bridge: RTL and testbench
====================================

Name: zacore_mem_bridge

Overview:
- Sits directly downstream of zacore_top. Terminates its fetch port and its data port with the req/ack handshake.
- Arbitrates both ports onto one single-ported synchronous SRAM with 1-cycle read latency.
- Replaces the zero-latency ideal memory used in simulation. Also lets FPGA builds map memory onto block RAM.

Parameters:
- ADDR_W, 14: word-address bits used to index the SRAM (16384 words).
- INIT_LAST_DATA, 1: reset value of the round-robin last-grant bit. 1 means fetch wins the first tie.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_fetch_req  in  1  instruction fetch request, held until acked
- o_fetch_ack  out  1  one-cycle completion pulse for fetch
- i_fetch_addr  in  32  word address; bits above ADDR_W ignored
- o_inst_read  out  32  fetched word, valid while o_fetch_ack=1
- i_read_req  in  1  data load request
- i_write_req  in  1  data store request
- o_read_ack  out  1  one-cycle load completion pulse
- o_write_ack  out  1  one-cycle store completion pulse
- i_data_addr  in  32  data word address; bits above ADDR_W ignored
- i_data_write  in  32  store data
- i_data_write_mask  in  4  byte enables; bit n covers bits [8n+7:8n]
- o_data_read  out  32  loaded word, valid while o_read_ack=1
- o_mem_en  out  1  SRAM access enable
- o_mem_we  out  4  SRAM byte write enables
- o_mem_addr  out  ADDR_W  SRAM word address
- o_mem_wdata  out  32  SRAM write data
- i_mem_rdata  in  32  SRAM read data, one cycle after o_mem_en

Behaviour:
- Reset (async assert, sync deassert by caller):
  - state=IDLE, resp_sel=NONE, last_grant=INIT_LAST_DATA.
  - All acks=0, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.
  - o_inst_read and o_data_read are don't-care unless their ack is high.
- Handshake:
  - Requester holds req, addr, data and mask stable until the cycle its ack is high.
  - A posedge with ack=1 completes the transaction.
  - A req still high in the following cycle is a new request.
- Candidates each cycle:
  - fetch = i_fetch_req and not (resp_sel==FETCH).
  - data = (i_read_req or i_write_req) and not (resp_sel in {READ, WRITE}).
- Grant rules:
  - One candidate: it wins.
  - Both: round-robin, the port not granted last wins. Update last_grant on every grant.
- Grant drives the SRAM port combinationally in the same cycle:
  - o_mem_en=1, o_mem_addr=addr[ADDR_W-1:0].
  - For a write: o_mem_we=mask and o_mem_wdata=i_data_write. Otherwise o_mem_we=0.
- i_read_req and i_write_req both high is illegal. Write wins and the read is not acked; a simulation assertion fires.
- Sequential part (two states):
  - IDLE: on a grant, go to RESP with resp_sel = grant type.
  - RESP: raise the ack for resp_sel.
    - FETCH: o_inst_read=i_mem_rdata.
    - READ: o_data_read=i_mem_rdata.
    - WRITE: ack only.
    - A new grant of the other port in the same cycle keeps the state at RESP, so back-to-back alternation gives 1 transaction/cycle. No grant returns to IDLE.
- Latency and throughput:
  - Ack arrives exactly 1 cycle after grant.
  - A single port alone sustains 1 transaction per 2 cycles.
- Boundary cases:
  - Mask=0 write: SRAM enabled with we=0; still acked.
  - Address aliasing: addresses modulo 2^ADDR_W.
  - Fetch and store to the same word in the same ack window: ordering follows grant order. A store granted before a fetch is visible to that fetch.
  - Reset mid-transaction: pending ack lost. A write already presented on the SRAM port may have committed.

Optional Feature:
- Macro: ZACORE_MEM_RDATA_REG_EN.
- Defined:
  - i_mem_rdata is captured into an internal register, adding state RESP_WAIT between grant and RESP.
  - Read, fetch and write acks all arrive 2 cycles after grant.
  - No grant is issued while in RESP_WAIT.
- Undefined: 1-cycle behaviour as above.

Decomposition:
- Package zacore_mem_pkg:
  - enum sel_t {SEL_NONE, SEL_FETCH, SEL_READ, SEL_WRITE}.
  - enum state_t {IDLE, RESP_WAIT, RESP}.
  - Constant WORD_BYTES=4.
- Sub-module zacore_mem_rr_arb: 2-requester round-robin with last_grant flop, exposing grant_fetch/grant_data.

Test Plan:
- Reset with i_rst_n=0 mid-RESP -> all acks and o_mem_en drop to 0 immediately, without waiting for a clock edge.
- Fetch only: SRAM word 0x10 preloaded 0xDEADBEEF; hold i_fetch_req, addr 0x10 -> o_fetch_ack on the 2nd cycle with o_inst_read=0xDEADBEEF; repeats every 2 cycles.
- Simultaneous fetch (0x4) and read (0x8) after reset -> fetch granted first, read granted in fetch's ack cycle; acks on consecutive cycles; then alternation.
- Store 0xAABBCCDD mask 4'b0101 to 0x20 (word was 0) -> o_mem_we=4'b0101 in grant cycle; o_write_ack next cycle; a later load reads 0x00BB00DD.
- Address 0x00004010 with ADDR_W=14 -> o_mem_addr=0x0010.
- With ZACORE_MEM_RDATA_REG_EN defined: read of 0x8 -> o_read_ack exactly 2 cycles after grant; no grant in the intervening cycle.

Source files
------------

// File: rtl/zacore_mem_pkg.sv
// zacore_mem_pkg
//   Shared types and constants for the zacore memory bridge.
//   sel_t   : which port owns the response slot (none, fetch, load, store)
//   state_t : bridge FSM states
//   WORD_BYTES : bytes per SRAM word (byte-enable width)
package zacore_mem_pkg;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_FETCH = 2'd1,
    SEL_READ  = 2'd2,
    SEL_WRITE = 2'd3
  } sel_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP_WAIT = 2'd1,
    RESP      = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/zacore_mem_rr_arb.sv
// zacore_mem_rr_arb
//   Two-requester round-robin arbiter (fetch vs data) with a last-grant flop.
//   Ports:
//     clk_i, rst_ni             clock, asynchronous active-low reset
//     req_fetch_i, req_data_i   qualified candidate requests
//     grant_fetch_o             fetch wins this cycle (combinational)
//     grant_data_o              data wins this cycle (combinational)
//   INIT_LAST_DATA sets the reset value of the "data granted last" bit, so
//   1 makes fetch win the first tie.
module zacore_mem_rr_arb #(
  parameter bit INIT_LAST_DATA = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_fetch_i,
  input  logic req_data_i,
  output logic grant_fetch_o,
  output logic grant_data_o
);

  logic last_data_q;
  logic last_data_d;

  always_comb begin
    // On a tie the port that did not win last time gets the slot.
    grant_fetch_o = req_fetch_i & (~req_data_i | last_data_q);
    grant_data_o  = req_data_i  & (~req_fetch_i | ~last_data_q);
    last_data_d   = last_data_q;
    if (grant_data_o) begin
      last_data_d = 1'b1;
    end else if (grant_fetch_o) begin
      last_data_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_data_q <= INIT_LAST_DATA;
    end else begin
      last_data_q <= last_data_d;
    end
  end

endmodule

// File: rtl/zacore_mem_bridge.sv
// zacore_mem_bridge
//   Terminates the zacore fetch and data req/ack ports and arbitrates them
//   onto one single-ported synchronous SRAM with 1-cycle read latency.
//   Ports:
//     i_clk, i_rst_n                       clock, async active-low reset
//     i_fetch_req/o_fetch_ack/i_fetch_addr instruction fetch port
//     o_inst_read                          fetched word (valid with ack)
//     i_read_req/i_write_req               data load/store requests
//     o_read_ack/o_write_ack               data completion pulses
//     i_data_addr/i_data_write/i_data_write_mask  data address, store data, byte enables
//     o_data_read                          loaded word (valid with ack)
//     o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata    SRAM command (same cycle as grant)
//     i_mem_rdata                          SRAM read data, one cycle after o_mem_en
//   Build option ZACORE_MEM_RDATA_REG_EN: registers SRAM read data through an
//   extra RESP_WAIT state; every ack then lands 2 cycles after its grant and no
//   grant is issued during RESP_WAIT.
module zacore_mem_bridge
  import zacore_mem_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter bit INIT_LAST_DATA = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fetch_req,
  output logic                  o_fetch_ack,
  input  logic [31:0]           i_fetch_addr,
  output logic [31:0]           o_inst_read,
  input  logic                  i_read_req,
  input  logic                  i_write_req,
  output logic                  o_read_ack,
  output logic                  o_write_ack,
  input  logic [31:0]           i_data_addr,
  input  logic [31:0]           i_data_write,
  input  logic [WORD_BYTES-1:0] i_data_write_mask,
  output logic [31:0]           o_data_read,
  output logic                  o_mem_en,
  output logic [WORD_BYTES-1:0] o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata
);

  state_t state_q, state_d;
  sel_t   sel_q, sel_d;
  sel_t   grant_sel;
  logic   fetch_ack_q, read_ack_q, write_ack_q;
  logic   hold;
  logic   cand_fetch, cand_data;
  logic   grant_fetch, grant_data, grant_any;
  logic [31:0] rdata;

  // Address bits above ADDR_W alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_fetch_addr[31:ADDR_W], i_data_addr[31:ADDR_W]};

  // A port is masked while its own ack is out, so a held req is not
  // re-granted until the ack posedge has retired it. Reset gates both so
  // the SRAM port goes quiet immediately on reset assertion.
  always_comb begin
    hold       = (state_q == RESP_WAIT);
    cand_fetch = i_rst_n & ~hold & i_fetch_req & (sel_q != SEL_FETCH);
    cand_data  = i_rst_n & ~hold & (i_read_req | i_write_req)
               & (sel_q != SEL_READ) & (sel_q != SEL_WRITE);
  end

  zacore_mem_rr_arb #(
    .INIT_LAST_DATA(INIT_LAST_DATA)
  ) u_arb (
    .clk_i         (i_clk),
    .rst_ni        (i_rst_n),
    .req_fetch_i   (cand_fetch),
    .req_data_i    (cand_data),
    .grant_fetch_o (grant_fetch),
    .grant_data_o  (grant_data)
  );

  assign grant_any = grant_fetch | grant_data;

  // SRAM command is driven combinationally in the grant cycle. A store wins
  // over a simultaneous (illegal) load on the data port.
  always_comb begin
    o_mem_en    = grant_any;
    o_mem_addr  = '0;
    o_mem_we    = '0;
    o_mem_wdata = '0;
    grant_sel   = SEL_NONE;
    if (grant_fetch) begin
      o_mem_addr = i_fetch_addr[ADDR_W-1:0];
      grant_sel  = SEL_FETCH;
    end else if (grant_data) begin
      o_mem_addr = i_data_addr[ADDR_W-1:0];
      if (i_write_req) begin
        o_mem_we    = i_data_write_mask;
        o_mem_wdata = i_data_write;
        grant_sel   = SEL_WRITE;
      end else begin
        grant_sel = SEL_READ;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
`ifdef ZACORE_MEM_RDATA_REG_EN
    case (state_q)
      RESP_WAIT: begin
        state_d = RESP;
      end
      IDLE, RESP: begin
        if (grant_any) begin
          state_d = RESP_WAIT;
          sel_d   = grant_sel;
        end else begin
          state_d = IDLE;
          sel_d   = SEL_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_NONE;
      end
    endcase
`else
    // Staying in RESP on a fresh grant lets alternating ports run at one
    // transaction per cycle.
    if (grant_any) begin
      state_d = RESP;
      sel_d   = grant_sel;
    end else begin
      state_d = IDLE;
      sel_d   = SEL_NONE;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      sel_q       <= SEL_NONE;
      fetch_ack_q <= 1'b0;
      read_ack_q  <= 1'b0;
      write_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      fetch_ack_q <= (state_d == RESP) && (sel_d == SEL_FETCH);
      read_ack_q  <= (state_d == RESP) && (sel_d == SEL_READ);
      write_ack_q <= (state_d == RESP) && (sel_d == SEL_WRITE);
    end
  end

`ifdef ZACORE_MEM_RDATA_REG_EN
  logic [31:0] rdata_q;

  // SRAM output is valid during RESP_WAIT; capture it for the RESP cycle.
  always_ff @(posedge i_clk) begin
    if (state_q == RESP_WAIT) begin
      rdata_q <= i_mem_rdata;
    end
  end

  assign rdata = rdata_q;
`else
  assign rdata = i_mem_rdata;
`endif

  assign o_fetch_ack = fetch_ack_q;
  assign o_read_ack  = read_ack_q;
  assign o_write_ack = write_ack_q;
  assign o_inst_read = rdata;
  assign o_data_read = rdata;

`ifndef SYNTHESIS
  // Load and store on the data port at once is a requester bug.
  rw_exclusive_a: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) !(i_read_req && i_write_req)
  );
`endif

endmodule

// File: tb/tb_zacore_mem_bridge.sv
module tb_zacore_mem_bridge;

  localparam int ADDR_W = 14;
`ifdef ZACORE_MEM_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [1:0] K_FETCH = 2'd1;
  localparam logic [1:0] K_READ  = 2'd2;
  localparam logic [1:0] K_WRITE = 2'd3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_req = 1'b0;
  logic              fetch_ack;
  logic [31:0]       fetch_addr = '0;
  logic [31:0]       inst_read;
  logic              read_req = 1'b0;
  logic              write_req = 1'b0;
  logic              read_ack;
  logic              write_ack;
  logic [31:0]       data_addr = '0;
  logic [31:0]       data_write = '0;
  logic [3:0]        data_mask = '0;
  logic [31:0]       data_read;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  always #5 clk = ~clk;

  zacore_mem_bridge #(.ADDR_W(ADDR_W), .INIT_LAST_DATA(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fetch_req(fetch_req), .o_fetch_ack(fetch_ack),
    .i_fetch_addr(fetch_addr), .o_inst_read(inst_read),
    .i_read_req(read_req), .i_write_req(write_req),
    .o_read_ack(read_ack), .o_write_ack(write_ack),
    .i_data_addr(data_addr), .i_data_write(data_write),
    .i_data_write_mask(data_mask), .o_data_read(data_read),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Behavioural single-port SRAM, read-first, 1-cycle latency.
  logic [31:0] sram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= sram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: expected completions in grant order.
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } sb_t;
  sb_t sbq[$];

  task automatic sb_push(input logic [1:0] kind, input logic [31:0] data);
    sb_t e;
    e.kind = kind;
    e.data = data;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input logic [1:0] kind, input logic [31:0] data);
    sb_t e;
    if (sbq.size() == 0) begin
      check("sb_unexpected_ack", {30'b0, kind}, 32'h0);
      return;
    end
    e = sbq.pop_front();
    check("sb_kind", {30'b0, kind}, {30'b0, e.kind});
    if (kind != K_WRITE) check("sb_data", data, e.data);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (fetch_ack) sb_pop(K_FETCH, inst_read);
      if (read_ack)  sb_pop(K_READ, data_read);
      if (write_ack) sb_pop(K_WRITE, 32'h0);
    end
  end

  typedef struct {
    logic        f, r, w;
    logic [31:0] addr, wdata;
    logic [3:0]  mask, exp_we;
    logic [31:0] exp_addr, exp_rdata;
  } vec_t;

  function automatic vec_t mkv(input logic f, input logic r, input logic w,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] mask, input logic [3:0] exp_we,
                               input logic [31:0] exp_addr, input logic [31:0] exp_rdata);
    vec_t v;
    v.f = f; v.r = r; v.w = w; v.addr = addr; v.wdata = wdata;
    v.mask = mask; v.exp_we = exp_we; v.exp_addr = exp_addr; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [2:0] exp_acks;
    @(negedge clk);
    fetch_req = v.f; read_req = v.r; write_req = v.w;
    fetch_addr = v.addr; data_addr = v.addr;
    data_write = v.wdata; data_mask = v.mask;
    #1;
    check($sformatf("v%0d_en", idx), {31'b0, mem_en}, 32'h1);
    check($sformatf("v%0d_we", idx), {28'b0, mem_we}, {28'b0, v.exp_we});
    check($sformatf("v%0d_addr", idx), {18'b0, mem_addr}, v.exp_addr);
    if (v.w) check($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
    sb_push(v.f ? K_FETCH : (v.w ? K_WRITE : K_READ), v.exp_rdata);
    exp_acks = v.f ? 3'b100 : (v.w ? 3'b001 : 3'b010);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    #1;
    check($sformatf("v%0d_acks", idx), {29'b0, fetch_ack, read_ack, write_ack}, {29'b0, exp_acks});
    fetch_req = 1'b0; read_req = 1'b0; write_req = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = 32'h0;
    sram[14'h10] = 32'hDEADBEEF;
    sram[14'h04] = 32'h11111111;
    sram[14'h08] = 32'h22222222;
    sram[14'h30] = 32'h55555555;

    //            f  r  w  addr          wdata         mask     exp_we   exp_addr  exp_rdata
    vecs[0] = mkv(1, 0, 0, 32'h10,       32'h0,        4'h0,    4'h0,    32'h10,   32'hDEADBEEF);
    vecs[1] = mkv(0, 0, 1, 32'h20,       32'hAABBCCDD, 4'b0101, 4'b0101, 32'h20,   32'h0);
    vecs[2] = mkv(0, 1, 0, 32'h20,       32'h0,        4'h0,    4'h0,    32'h20,   32'h00BB00DD);
    vecs[3] = mkv(0, 1, 0, 32'h00004010, 32'h0,        4'h0,    4'h0,    32'h0010, 32'hDEADBEEF);
    vecs[4] = mkv(0, 0, 1, 32'h30,       32'h12345678, 4'h0,    4'h0,    32'h30,   32'h0);
    vecs[5] = mkv(0, 1, 0, 32'h30,       32'h0,        4'h0,    4'h0,    32'h30,   32'h55555555);
    vecs[6] = mkv(0, 0, 1, 32'hFFFFC040, 32'hCAFEF00D, 4'hF,    4'hF,    32'h0040, 32'h0);
    vecs[7] = mkv(1, 0, 0, 32'h40,       32'h0,        4'h0,    4'h0,    32'h40,   32'hCAFEF00D);
    vecs[8] = mkv(0, 0, 1, 32'h40,       32'h99000000, 4'b1000, 4'b1000, 32'h40,   32'h0);
    vecs[9] = mkv(0, 1, 0, 32'h40,       32'h0,        4'h0,    4'h0,    32'h40,   32'h99FEF00D);

    // Reset state with requests pending: SRAM port and acks stay quiet.
    fetch_req = 1'b1; write_req = 1'b1; data_mask = 4'hF;
    fetch_addr = 32'h123; data_addr = 32'h456; data_write = 32'hFFFFFFFF;
    #12;
    check("rst_acks", {29'b0, fetch_ack, read_ack, write_ack}, 32'h0);
    check("rst_en", {31'b0, mem_en}, 32'h0);
    check("rst_we", {28'b0, mem_we}, 32'h0);
    check("rst_addr", {18'b0, mem_addr}, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    fetch_req = 1'b0; write_req = 1'b0; data_mask = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Single port held: one fetch every LAT+1 cycles.
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h10;
    for (int i = 0; i < 3; i++) sb_push(K_FETCH, 32'hDEADBEEF);
    for (int k = 0; k < 3 * (LAT + 1); k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("rep%0d_ack", k), {31'b0, fetch_ack}, {31'b0, (k % (LAT + 1)) == LAT});
      check($sformatf("rep%0d_en", k), {31'b0, mem_en}, {31'b0, (k % (LAT + 1)) == 0});
    end
    fetch_req = 1'b0;

    // Reset while an ack is out: ack and SRAM enable drop without a clock.
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h10;
    repeat (LAT) @(posedge clk);
    #1;
    check("mid_pre_ack", {31'b0, fetch_ack}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_acks", {29'b0, fetch_ack, read_ack, write_ack}, 32'h0);
    check("mid_rst_en", {31'b0, mem_en}, 32'h0);
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

`ifndef ZACORE_MEM_RDATA_REG_EN
    // Fetch and load together right after reset: fetch first, then alternate.
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h4;
    read_req = 1'b1; data_addr = 32'h8;
    sb_push(K_FETCH, 32'h11111111); sb_push(K_READ, 32'h22222222);
    sb_push(K_FETCH, 32'h11111111); sb_push(K_READ, 32'h22222222);
    #1;
    check("alt0_acks", {29'b0, fetch_ack, read_ack, write_ack}, 32'h0);
    check("alt0_addr", {18'b0, mem_addr}, 32'h4);
    @(negedge clk); #1;
    check("alt1_acks", {29'b0, fetch_ack, read_ack, write_ack}, 32'h4);
    check("alt1_addr", {18'b0, mem_addr}, 32'h8);
    @(negedge clk); #1;
    check("alt2_acks", {29'b0, fetch_ack, read_ack, write_ack}, 32'h2);
    check("alt2_addr", {18'b0, mem_addr}, 32'h4);
    @(negedge clk); #1;
    check("alt3_acks", {29'b0, fetch_ack, read_ack, write_ack}, 32'h4);
    check("alt3_addr", {18'b0, mem_addr}, 32'h8);
    fetch_req = 1'b0;
    @(negedge clk); #1;
    check("alt4_acks", {29'b0, fetch_ack, read_ack, write_ack}, 32'h2);
    check("alt4_en", {31'b0, mem_en}, 32'h0);
    read_req = 1'b0;
`else
    // Registered read data: ack 2 cycles after grant, no grant in between.
    @(negedge clk);
    read_req = 1'b1; data_addr = 32'h8;
    sb_push(K_READ, 32'h22222222); sb_push(K_FETCH, 32'hDEADBEEF);
    #1;
    check("rw0_en", {31'b0, mem_en}, 32'h1);
    check("rw0_addr", {18'b0, mem_addr}, 32'h8);
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h10;
    #1;
    check("rw1_en", {31'b0, mem_en}, 32'h0);
    check("rw1_acks", {29'b0, fetch_ack, read_ack, write_ack}, 32'h0);
    @(negedge clk); #1;
    check("rw2_acks", {29'b0, fetch_ack, read_ack, write_ack}, 32'h2);
    check("rw2_addr", {18'b0, mem_addr}, 32'h10);
    read_req = 1'b0;
    @(negedge clk); #1;
    check("rw3_en", {31'b0, mem_en}, 32'h0);
    @(negedge clk); #1;
    check("rw4_acks", {29'b0, fetch_ack, read_ack, write_ack}, 32'h4);
    fetch_req = 1'b0;
`endif

    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    check("sb_drain", sbq.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
